// File: rtl/flash_reader_pkg.sv
// Shared types and helpers for the flash burst reader.
// State encoding, the all-lanes byteenable constant and the burst-length rule.
package flash_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    DONE
  } state_e;

  localparam logic [3:0] BYTEEN_ALL = 4'b1111;

  // Reverse playback walks one word at a time, so its bursts are always single beats.
  function automatic logic [6:0] burst_len(input logic [31:0] remaining,
                                           input logic [31:0] max_burst,
                                           input logic        rev);
    logic [31:0] len;
    if (rev) begin
      len = 32'd1;
    end else if (remaining < max_burst) begin
      len = remaining;
    end else begin
      len = max_burst;
    end
    return 7'(len);
  endfunction

endpackage

// File: rtl/flash_watchdog.sv
// Stall watchdog for flash_burst_reader, built only when FLASH_TIMEOUT_EN is defined.
// Counts cycles spent waiting on the flash and fires once TIMEOUT_CYC cycles pass without progress.
`ifdef FLASH_TIMEOUT_EN
module flash_watchdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired_o = run_i && !clear_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!run_i || clear_i || expired_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/flash_burst_reader.sv
// Avalon-MM flash read master: splits a (start address, word count) job into bursts.
// Optional stall watchdog enabled by defining FLASH_TIMEOUT_EN.
module flash_burst_reader
  import flash_reader_pkg::*;
#(
  parameter int ADDR_W      = 23,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16,
  parameter int MAX_BURST   = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              reverse,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [3:0]        flash_mem_byteenable,
  output logic [6:0]        flash_mem_burstcount,
  input  logic              flash_mem_waitrequest,
  input  logic              flash_mem_readdatavalid,
  input  logic [DATA_W-1:0] flash_mem_readdata
);

  if (MAX_BURST < 1 || MAX_BURST > 64 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("flash_burst_reader: MAX_BURST must be 1..64 and TIMEOUT_CYC at least 1");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              rev_q, rev_d;
  logic [6:0]        burst_q, burst_d;
  logic [6:0]        beat_q, beat_d;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;

  logic [CNT_W-1:0]  rem_after;
  logic              beat_fire;
  logic              beat_last;

  assign beat_fire = (state_q == WAIT_DATA) && flash_mem_readdatavalid;
  assign beat_last = (beat_q + 7'd1) == burst_q;
  assign rem_after = remaining_q - CNT_W'(burst_q);

`ifdef FLASH_TIMEOUT_EN
  logic error_q, error_d;
  logic wd_expired;

  flash_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .run_i    ((state_q == REQ) || (state_q == WAIT_DATA)),
    .clear_i  (((state_q == REQ) && !flash_mem_waitrequest) || beat_fire),
    .expired_o(wd_expired)
  );

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    rev_d       = rev_q;
    burst_d     = burst_q;
    beat_d      = beat_q;
`ifdef FLASH_TIMEOUT_EN
    error_d     = error_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = start_addr;
          remaining_d = word_count;
          rev_d       = reverse;
          beat_d      = '0;
`ifdef FLASH_TIMEOUT_EN
          error_d     = 1'b0;
`endif
          if (word_count != '0) begin
            burst_d = burst_len(32'(word_count), 32'(MAX_BURST), reverse);
            state_d = REQ;
          end else begin
            state_d = DONE;
          end
        end
      end
      REQ: begin
        if (!flash_mem_waitrequest) begin
          beat_d  = '0;
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (flash_mem_readdatavalid) begin
          if (beat_last) begin
            beat_d      = '0;
            remaining_d = rem_after;
            addr_d      = rev_q ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(burst_q));
            if (rem_after != '0) begin
              burst_d = burst_len(32'(rem_after), 32'(MAX_BURST), rev_q);
              state_d = REQ;
            end else begin
              state_d = DONE;
            end
          end else begin
            beat_d = beat_q + 7'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef FLASH_TIMEOUT_EN
    // A stalled flash still ends the job with a done pulse, flagged by the sticky error.
    if (wd_expired) begin
      error_d = 1'b1;
      state_d = DONE;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      rev_q       <= 1'b0;
      burst_q     <= '0;
      beat_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
`ifdef FLASH_TIMEOUT_EN
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      rev_q       <= rev_d;
      burst_q     <= burst_d;
      beat_q      <= beat_d;
      valid_q     <= beat_fire;
      if (beat_fire) begin
        data_q <= flash_mem_readdata;
      end
`ifdef FLASH_TIMEOUT_EN
      error_q     <= error_d;
`endif
    end
  end

  assign busy                 = (state_q != IDLE);
  assign done                 = (state_q == DONE);
  assign data_out             = data_q;
  assign data_valid           = valid_q;
  assign flash_mem_read       = (state_q == REQ);
  assign flash_mem_address    = addr_q;
  assign flash_mem_byteenable = BYTEEN_ALL;
  assign flash_mem_burstcount = burst_q;

endmodule

// File: tb/tb_flash_burst_reader.sv
// Self-checking bench for flash_burst_reader with a behavioural flash slave and job model.
// The timeout scenario is exercised only when FLASH_TIMEOUT_EN is defined.
module tb_flash_burst_reader;

  localparam int ADDR_W      = 23;
  localparam int DATA_W      = 32;
  localparam int CNT_W       = 16;
  localparam int MAX_BURST   = 16;
  localparam int TIMEOUT_CYC = 1024;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [CNT_W-1:0]  word_count;
  logic              reverse;
  logic              busy;
  logic              done;
  logic              error;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic [3:0]        flash_mem_byteenable;
  logic [6:0]        flash_mem_burstcount;
  logic              flash_mem_waitrequest;
  logic              flash_mem_readdatavalid;
  logic [DATA_W-1:0] flash_mem_readdata;

  int checks   = 0;
  int failures = 0;

  flash_burst_reader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .CNT_W      (CNT_W),
    .MAX_BURST  (MAX_BURST),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .start_addr             (start_addr),
    .word_count             (word_count),
    .reverse                (reverse),
    .busy                   (busy),
    .done                   (done),
    .error                  (error),
    .data_out               (data_out),
    .data_valid             (data_valid),
    .flash_mem_read         (flash_mem_read),
    .flash_mem_address      (flash_mem_address),
    .flash_mem_byteenable   (flash_mem_byteenable),
    .flash_mem_burstcount   (flash_mem_burstcount),
    .flash_mem_waitrequest  (flash_mem_waitrequest),
    .flash_mem_readdatavalid(flash_mem_readdatavalid),
    .flash_mem_readdata     (flash_mem_readdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Flash contents are a fixed scramble of the word address.
  function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
    return {9'h1A5, a} ^ {a[15:0], 16'hC3C3};
  endfunction

  // Slave configuration and state.
  logic [ADDR_W-1:0] beatQ[$];
  bit                randWait    = 1'b0;
  bit                randGap     = 1'b0;
  bit                holdWait    = 1'b0;
  int                stallCycles = 0;
  int                rdvPulses   = 0;
  bit                acceptedLast = 1'b0;
  logic [ADDR_W-1:0] lastAddr;
  logic [6:0]        lastBurst;

  // Slave: updates its outputs just after each rising edge, queuing beats for accepted reads.
  initial begin
    flash_mem_waitrequest   = 1'b0;
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata      = '0;
    forever begin
      @(posedge clk);
      #1;
      if (acceptedLast) begin
        for (int k = 0; k < int'(lastBurst); k++) beatQ.push_back(lastAddr + ADDR_W'(k));
      end
      if (beatQ.size() > 0 && (!randGap || $urandom_range(0, 3) != 0)) begin
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata      = memWord(beatQ.pop_front());
        rdvPulses++;
      end else begin
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = $urandom();
      end
      if (holdWait) flash_mem_waitrequest = 1'b1;
      else if (flash_mem_read && stallCycles > 0) begin
        flash_mem_waitrequest = 1'b1;
        stallCycles--;
      end else if (randWait) flash_mem_waitrequest = ($urandom_range(0, 2) == 0);
      else flash_mem_waitrequest = 1'b0;
      acceptedLast = flash_mem_read && !flash_mem_waitrequest && !reset;
      lastAddr     = flash_mem_address;
      lastBurst    = flash_mem_burstcount;
    end
  end

  // Observed activity collected on falling edges.
  logic [ADDR_W-1:0] obsAddr[$];
  logic [6:0]        obsBurst[$];
  logic [DATA_W-1:0] obsData[$];
  int                reqCycles[$];
  int                doneCount, readCycles, stabErr, curReqCycles;
  bit                prevHeld;
  logic [ADDR_W-1:0] prevAddr;
  logic [6:0]        prevBurst;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (prevHeld && (flash_mem_read !== 1'b1 || flash_mem_address !== prevAddr ||
                         flash_mem_burstcount !== prevBurst)) stabErr++;
        prevHeld  = flash_mem_read && flash_mem_waitrequest;
        prevAddr  = flash_mem_address;
        prevBurst = flash_mem_burstcount;
        if (flash_mem_read) begin
          readCycles++;
          curReqCycles++;
          if (!flash_mem_waitrequest) begin
            obsAddr.push_back(flash_mem_address);
            obsBurst.push_back(flash_mem_burstcount);
            reqCycles.push_back(curReqCycles);
            curReqCycles = 0;
          end
        end
        if (data_valid) obsData.push_back(data_out);
        if (done) doneCount++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetValues(input string where);
    checkOutput({where, ".read"},       64'(flash_mem_read), 64'(0));
    checkOutput({where, ".busy"},       64'(busy), 64'(0));
    checkOutput({where, ".done"},       64'(done), 64'(0));
    checkOutput({where, ".error"},      64'(error), 64'(0));
    checkOutput({where, ".dataValid"},  64'(data_valid), 64'(0));
    checkOutput({where, ".dataOut"},    64'(data_out), 64'(0));
    checkOutput({where, ".address"},    64'(flash_mem_address), 64'(0));
    checkOutput({where, ".burstcount"}, 64'(flash_mem_burstcount), 64'(0));
  endtask

  task automatic startJob(input logic [ADDR_W-1:0] a, input int count, input bit rev);
    for (int c = 0; c < 200 && beatQ.size() > 0; c++) @(posedge clk);
    @(posedge clk);
    #1;
    obsAddr.delete();
    obsBurst.delete();
    obsData.delete();
    reqCycles.delete();
    doneCount    = 0;
    readCycles   = 0;
    stabErr      = 0;
    curReqCycles = 0;
    prevHeld     = 1'b0;
    start_addr   = a;
    word_count   = CNT_W'(count);
    reverse      = rev;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    start_addr = ADDR_W'($urandom());
    word_count = CNT_W'($urandom());
    reverse    = 1'($urandom());
  endtask

  task automatic finishJob(input int budget, output int latency);
    latency = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      #1;
      if (doneCount > 0) begin
        latency = c;
        break;
      end
    end
    checkOutput("doneWithinBudget", 64'(latency > 0), 64'(1));
    if (latency > 0) begin
      @(negedge clk);
      #1;
      checkOutput("busyAfterDone", 64'(busy), 64'(0));
      checkOutput("donePulseWidth", 64'(done), 64'(0));
    end
  endtask

  // Reference model: request list from the burst rule, data from word-by-word address arithmetic.
  task automatic verifyJob(input logic [ADDR_W-1:0] a, input int count, input bit rev);
    logic [ADDR_W-1:0] expA[$];
    int                expB[$];
    logic [ADDR_W-1:0] cur = a;
    int                rem = count;
    int                b;
    while (rem > 0) begin
      b = rev ? 1 : ((rem < MAX_BURST) ? rem : MAX_BURST);
      expA.push_back(cur);
      expB.push_back(b);
      cur = rev ? cur - ADDR_W'(1) : cur + ADDR_W'(b);
      rem -= b;
    end
    checkOutput("reqCount", 64'(obsAddr.size()), 64'(expA.size()));
    for (int i = 0; i < expA.size() && i < obsAddr.size(); i++) begin
      checkOutput($sformatf("reqAddr[%0d]", i), 64'(obsAddr[i]), 64'(expA[i]));
      checkOutput($sformatf("reqBurst[%0d]", i), 64'(obsBurst[i]), 64'(expB[i]));
    end
    checkOutput("dataCount", 64'(obsData.size()), 64'(count));
    for (int i = 0; i < count && i < obsData.size(); i++) begin
      checkOutput($sformatf("data[%0d]", i), 64'(obsData[i]),
                  64'(memWord(rev ? a - ADDR_W'(i) : a + ADDR_W'(i))));
    end
    checkOutput("doneCount", 64'(doneCount), 64'(1));
    checkOutput("reqStable", 64'(stabErr), 64'(0));
    checkOutput("errorLow", 64'(error), 64'(0));
  endtask

  task automatic applyStimulus(input logic [ADDR_W-1:0] a, input int count, input bit rev);
    int lat;
    startJob(a, count, rev);
    finishJob(count * 10 + 100, lat);
    verifyJob(a, count, rev);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL globalTimeout simulation did not finish");
    $fatal(1, "[TB] global time limit");
  end

  initial begin
    int lat;
    int pulsesAtReset;
    int dataAtReset;
    logic [ADDR_W-1:0] ra;
    int rc;
    bit rr;

    reset      = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    word_count = '0;
    reverse    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("inReset");
    checkOutput("byteenable", 64'(flash_mem_byteenable), 64'(4'hF));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    checkResetValues("afterReset");

    $display("[TB] forward 40 words from 0x100");
    applyStimulus(23'h000100, 40, 1'b0);

    $display("[TB] waitrequest held for 5 cycles");
    stallCycles = 5;
    applyStimulus(23'h002000, 4, 1'b0);
    checkOutput("stallAcceptCycle", 64'(reqCycles.size() > 0 ? reqCycles[0] : 0), 64'(6));

    $display("[TB] reverse 3 words across address zero");
    applyStimulus(23'h000001, 3, 1'b1);

    $display("[TB] empty job");
    startJob(23'h000055, 0, 1'b0);
    finishJob(10, lat);
    checkOutput("emptyLatency", 64'(lat >= 1 && lat <= 2), 64'(1));
    checkOutput("emptyNoRead", 64'(readCycles), 64'(0));
    verifyJob(23'h000055, 0, 1'b0);

    $display("[TB] start while busy is ignored");
    randWait = 1'b1;
    randGap  = 1'b1;
    startJob(23'h003000, 20, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = 23'h007777;
    word_count = 16'd5;
    reverse    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    finishJob(400, lat);
    verifyJob(23'h003000, 20, 1'b0);

    $display("[TB] forward wrap past all-ones");
    applyStimulus(23'h7FFFF8, 20, 1'b0);

    $display("[TB] randomized jobs");
    for (int j = 0; j < 8; j++) begin
      ra = ADDR_W'($urandom());
      rc = $urandom_range(0, 50);
      rr = 1'($urandom_range(0, 1));
      applyStimulus(ra, rc, rr);
    end

    $display("[TB] reset during WAIT_DATA with stale beats");
    randWait = 1'b0;
    startJob(23'h004000, 16, 1'b0);
    for (int c = 0; c < 200 && obsData.size() < 3; c++) @(negedge clk);
    checkOutput("midBurstReached", 64'(obsData.size() >= 3), 64'(1));
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkResetValues("abort");
    pulsesAtReset = rdvPulses;
    dataAtReset   = obsData.size();
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    checkOutput("staleBeatsSeen", 64'((rdvPulses - pulsesAtReset) >= 2), 64'(1));
    checkOutput("noStaleData", 64'(obsData.size()), 64'(dataAtReset));
    checkOutput("noDoneAfterAbort", 64'(doneCount), 64'(0));
    checkOutput("idleAfterAbort", 64'(busy), 64'(0));
    applyStimulus(23'h000010, 5, 1'b1);

`ifdef FLASH_TIMEOUT_EN
    $display("[TB] watchdog timeout");
    randGap  = 1'b0;
    holdWait = 1'b1;
    startJob(23'h000500, 4, 1'b0);
    finishJob(TIMEOUT_CYC + 50, lat);
    checkOutput("timeoutError", 64'(error), 64'(1));
    checkOutput("timeoutDone", 64'(doneCount), 64'(1));
    checkOutput("timeoutNoAccept", 64'(obsAddr.size()), 64'(0));
    holdWait = 1'b0;
    startJob(23'h000600, 2, 1'b0);
    checkOutput("errorClearedByStart", 64'(error), 64'(0));
    finishJob(100, lat);
    verifyJob(23'h000600, 2, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
